// File: rtl/kernel_cc_pkg.sv
// Shared types, constants and field helpers for the kernel_cc label stages.
package kernel_cc_pkg;

    localparam int unsigned KCC_VID_W  = 32;
    localparam int unsigned KCC_LBL_W  = 32;
    localparam int unsigned KCC_DATA_W = KCC_VID_W + KCC_LBL_W;

    // Vertex id reserved as the end-of-stream marker.
    localparam logic [KCC_VID_W-1:0] EOS_VID = {KCC_VID_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EOS  = 2'd1,
        ST_DONE = 2'd2
    } kcc_state_e;

    typedef struct packed {
        logic [KCC_VID_W-1:0] vid;
        logic [KCC_LBL_W-1:0] lbl;
    } kcc_word_t;

    function automatic logic [KCC_VID_W-1:0] kcc_get_vid(input logic [KCC_DATA_W-1:0] w);
        return w[KCC_DATA_W-1:KCC_LBL_W];
    endfunction

    function automatic logic [KCC_LBL_W-1:0] kcc_get_lbl(input logic [KCC_DATA_W-1:0] w);
        return w[KCC_LBL_W-1:0];
    endfunction

    function automatic logic [KCC_DATA_W-1:0] kcc_make_word(input logic [KCC_VID_W-1:0] vid,
                                                           input logic [KCC_LBL_W-1:0] lbl);
        return {vid, lbl};
    endfunction

endpackage

// File: rtl/kernel_cc_label_coalesce_outreg.sv
// One-entry output holding register: load when ready, drains when downstream accepts.
module kernel_cc_label_coalesce_outreg #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_full_n,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ready_c
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Entry can accept a new word if empty or being drained this cycle.
    assign ready_c   = !valid_q | out_full_n;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next entry contents: a load overrides a drain; data holds while not loading.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_full_n) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/kernel_cc_label_coalesce.sv
// Merges runs of equal-vid {vid,label} words into one word carrying the minimum label.
module kernel_cc_label_coalesce
    import kernel_cc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned VID_WIDTH  = 32,
    parameter int unsigned LBL_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_empty_n,
    output logic                  in_read,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  out_full_n,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  start,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  in_cnt,
    output logic [CNT_WIDTH-1:0]  out_cnt
);

    localparam logic [VID_WIDTH-1:0]  EOS_VID_P = {VID_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] EOS_WORD  = {EOS_VID_P, {LBL_WIDTH{1'b0}}};

    kcc_state_e state_q, state_d;

    logic                 pend_valid_q, pend_valid_d;
    logic [VID_WIDTH-1:0] pend_vid_q, pend_vid_d;
    logic [LBL_WIDTH-1:0] pend_lbl_q, pend_lbl_d;
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    logic                  ld_c;
    logic [DATA_WIDTH-1:0] ld_data_c;
    logic                  ready_c;
    logic                  out_valid_c;
    logic                  pop_c;
    logic                  is_eos_c;
    logic [VID_WIDTH-1:0]  in_vid_c;
    logic [LBL_WIDTH-1:0]  in_lbl_c;

    assign in_vid_c = in_dout[DATA_WIDTH-1:LBL_WIDTH];
    assign in_lbl_c = in_dout[LBL_WIDTH-1:0];
    assign is_eos_c = (in_vid_c == EOS_VID_P);

    // Pop decision never looks at the head word, only at flow control and state.
    assign pop_c   = !reset & in_empty_n & ready_c & (state_q == ST_RUN);
    assign in_read = pop_c;

    assign out_write = out_valid_c;
    assign done      = (state_q == ST_DONE) & !out_valid_c;
    assign in_cnt    = in_cnt_q;
    assign out_cnt   = out_cnt_q;

    kernel_cc_label_coalesce_outreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (ld_c),
        .load_data  (ld_data_c),
        .out_full_n (out_full_n),
        .out_valid  (out_valid_c),
        .out_data   (out_din),
        .ready_c    (ready_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pop_c && is_eos_c) begin
                    state_d = pend_valid_q ? ST_EOS : ST_DONE;
                end
            end
            ST_EOS: begin
                if (ready_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Merge datapath, output-register loads and counters.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_vid_d   = pend_vid_q;
        pend_lbl_d   = pend_lbl_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        ld_c         = 1'b0;
        ld_data_c    = {pend_vid_q, pend_lbl_q};
        case (state_q)
            ST_RUN: begin
                if (pop_c) begin
                    if (is_eos_c) begin
                        // Flush any pending run first; the marker follows from ST_EOS.
                        ld_c = 1'b1;
                        if (pend_valid_q) begin
                            pend_valid_d = 1'b0;
                            out_cnt_d    = out_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            ld_data_c = EOS_WORD;
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
                        if (!pend_valid_q) begin
                            pend_valid_d = 1'b1;
                            pend_vid_d   = in_vid_c;
                            pend_lbl_d   = in_lbl_c;
                        end else if (in_vid_c == pend_vid_q) begin
                            if (in_lbl_c < pend_lbl_q) begin
                                pend_lbl_d = in_lbl_c;
                            end
                        end else begin
                            ld_c       = 1'b1;
                            out_cnt_d  = out_cnt_q + CNT_WIDTH'(1);
                            pend_vid_d = in_vid_c;
                            pend_lbl_d = in_lbl_c;
                        end
                    end
                end
            end
            ST_EOS: begin
                if (ready_c) begin
                    ld_c      = 1'b1;
                    ld_data_c = EOS_WORD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            default: begin
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // Pending-run and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_vid_q   <= '0;
            pend_lbl_q   <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_vid_q   <= pend_vid_d;
            pend_lbl_q   <= pend_lbl_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_kernel_cc_label_coalesce.sv
// Directed bench for kernel_cc_label_coalesce with a model upstream FIFO and output capture.
module tb_kernel_cc_label_coalesce;

    localparam logic [63:0] EOS_WORD = 64'hFFFF_FFFF_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_empty_n;
    logic        in_read;
    logic [63:0] in_dout;
    logic        out_full_n = 1'b1;
    logic        out_write;
    logic [63:0] out_din;
    logic        start = 1'b0;
    logic        done;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;

    logic [63:0] mem [0:63];
    int          head = 0;
    int          tail = 0;
    logic        fifo_clr = 1'b1;
    logic [63:0] cap [0:63];
    int          cap_n = 0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    kernel_cc_label_coalesce dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .start      (start),
        .done       (done),
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt)
    );

    assign in_empty_n = (head != tail);
    assign in_dout    = mem[head % 64];

    // Upstream FIFO pop and downstream capture.
    always @(posedge clk) begin
        if (fifo_clr) head <= tail;
        else if (in_read) head <= head + 1;
        if (out_write && out_full_n) begin
            cap[cap_n % 64] <= out_din;
            cap_n <= cap_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v, input logic [31:0] l);
        mem[tail % 64] = {v, l};
        tail = tail + 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        fifo_clr = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        push(32'd1, 32'd1);
        tick();
        n_checks++; if (in_read !== 1'b0) begin n_fails++; $display("FAIL rst_in_read: got %b expected 0", in_read); end
        n_checks++; if (out_write !== 1'b0) begin n_fails++; $display("FAIL rst_out_write: got %b expected 0", out_write); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (in_cnt !== 32'd0) begin n_fails++; $display("FAIL rst_in_cnt: got %0d expected 0", in_cnt); end
        n_checks++; if (out_cnt !== 32'd0) begin n_fails++; $display("FAIL rst_out_cnt: got %0d expected 0", out_cnt); end
        tick();
        reset = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic test_merge_basic();
        logic [63:0] exp_w [0:2];
        int base;
        bit seen;
        exp_w[0] = {32'd5, 32'd3};
        exp_w[1] = {32'd8, 32'd1};
        exp_w[2] = EOS_WORD;
        apply_reset();
        base = cap_n;
        push(32'd5, 32'd9); push(32'd5, 32'd3); push(32'd5, 32'd7); push(32'd8, 32'd1);
        push(32'hFFFF_FFFF, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_write && out_full_n && out_din == EOS_WORD) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) begin n_fails++; $display("FAIL t1_eos_seen: got %b expected 1", seen); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL t1_done_before_push: got %b expected 0", done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL t1_done_after_push: got %b expected 1", done); end
        n_checks++; if (cap_n - base !== 3) begin n_fails++; $display("FAIL t1_push_count: got %0d expected 3", cap_n - base); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cap[(base + i) % 64] !== exp_w[i]) begin
                n_fails++; $display("FAIL t1_word%0d: got %h expected %h", i, cap[(base + i) % 64], exp_w[i]);
            end
        end
        n_checks++; if (in_cnt !== 32'd4) begin n_fails++; $display("FAIL t1_in_cnt: got %0d expected 4", in_cnt); end
        n_checks++; if (out_cnt !== 32'd2) begin n_fails++; $display("FAIL t1_out_cnt: got %0d expected 2", out_cnt); end
    endtask

    task automatic test_eos_only();
        int base;
        bit ok;
        apply_reset();
        base = cap_n;
        push(32'hFFFF_FFFF, 32'h0000_1234);
        wait_done(20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t2_done: got %b expected 1", ok); end
        n_checks++; if (cap_n - base !== 1) begin n_fails++; $display("FAIL t2_push_count: got %0d expected 1", cap_n - base); end
        n_checks++; if (cap[base % 64] !== EOS_WORD) begin n_fails++; $display("FAIL t2_eos_word: got %h expected %h", cap[base % 64], EOS_WORD); end
        n_checks++; if (out_cnt !== 32'd0) begin n_fails++; $display("FAIL t2_out_cnt: got %0d expected 0", out_cnt); end
        n_checks++; if (in_cnt !== 32'd0) begin n_fails++; $display("FAIL t2_in_cnt: got %0d expected 0", in_cnt); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_w [0:3];
        int base;
        int bad;
        bit ok;
        exp_w[0] = {32'd1, 32'd4};
        exp_w[1] = {32'd2, 32'd6};
        exp_w[2] = {32'd3, 32'd2};
        exp_w[3] = EOS_WORD;
        apply_reset();
        base = cap_n;
        out_full_n = 1'b0;
        push(32'd1, 32'd4); push(32'd2, 32'd6); push(32'd3, 32'd2); push(32'hFFFF_FFFF, 32'd0);
        tick(); tick(); tick();
        n_checks++; if (in_read !== 1'b0) begin n_fails++; $display("FAIL t3_in_read_stall: got %b expected 0", in_read); end
        n_checks++; if (out_write !== 1'b1) begin n_fails++; $display("FAIL t3_out_write_held: got %b expected 1", out_write); end
        n_checks++; if (out_din !== exp_w[0]) begin n_fails++; $display("FAIL t3_out_din_held: got %h expected %h", out_din, exp_w[0]); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_din !== exp_w[0] || in_read !== 1'b0 || out_write !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL t3_hold_stable: got %0d unstable cycles expected 0", bad); end
        out_full_n = 1'b1;
        wait_done(40, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t3_done: got %b expected 1", ok); end
        n_checks++; if (cap_n - base !== 4) begin n_fails++; $display("FAIL t3_push_count: got %0d expected 4", cap_n - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap[(base + i) % 64] !== exp_w[i]) begin
                n_fails++; $display("FAIL t3_word%0d: got %h expected %h", i, cap[(base + i) % 64], exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_w [0:4];
        int base;
        bit ok;
        exp_w[0] = {32'd1, 32'd10};
        exp_w[1] = {32'd2, 32'd20};
        exp_w[2] = {32'd1, 32'd5};
        exp_w[3] = {32'd2, 32'd6};
        exp_w[4] = EOS_WORD;
        apply_reset();
        base = cap_n;
        push(32'd1, 32'd10); push(32'd2, 32'd20); push(32'd1, 32'd5); push(32'd2, 32'd6);
        push(32'hFFFF_FFFF, 32'd0);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t4_done: got %b expected 1", ok); end
        n_checks++; if (cap_n - base !== 5) begin n_fails++; $display("FAIL t4_push_count: got %0d expected 5", cap_n - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap[(base + i) % 64] !== exp_w[i]) begin
                n_fails++; $display("FAIL t4_word%0d: got %h expected %h", i, cap[(base + i) % 64], exp_w[i]);
            end
        end
        n_checks++; if (in_cnt !== 32'd4) begin n_fails++; $display("FAIL t4_in_cnt: got %0d expected 4", in_cnt); end
        n_checks++; if (out_cnt !== 32'd4) begin n_fails++; $display("FAIL t4_out_cnt: got %0d expected 4", out_cnt); end
    endtask

    task automatic test_reset_midrun();
        int base;
        bit ok;
        apply_reset();
        out_full_n = 1'b0;
        push(32'd6, 32'd1); push(32'd7, 32'd2); push(32'd7, 32'd9);
        tick(); tick(); tick(); tick();
        n_checks++; if (out_din !== {32'd6, 32'd1}) begin n_fails++; $display("FAIL t5_held_word: got %h expected %h", out_din, {32'd6, 32'd1}); end
        reset = 1'b1;
        fifo_clr = 1'b1;
        #1;
        n_checks++; if (in_read !== 1'b0) begin n_fails++; $display("FAIL t5_in_read_in_reset: got %b expected 0", in_read); end
        tick();
        n_checks++; if (out_write !== 1'b0) begin n_fails++; $display("FAIL t5_out_write: got %b expected 0", out_write); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL t5_done: got %b expected 0", done); end
        n_checks++; if (in_cnt !== 32'd0 || out_cnt !== 32'd0) begin n_fails++; $display("FAIL t5_counters: got %0d/%0d expected 0/0", in_cnt, out_cnt); end
        reset = 1'b0;
        fifo_clr = 1'b0;
        out_full_n = 1'b1;
        base = cap_n;
        push(32'd4, 32'd4); push(32'hFFFF_FFFF, 32'd0);
        wait_done(20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t5_stream_done: got %b expected 1", ok); end
        n_checks++; if (cap_n - base !== 2) begin n_fails++; $display("FAIL t5_push_count: got %0d expected 2", cap_n - base); end
        n_checks++; if (cap[base % 64] !== {32'd4, 32'd4}) begin n_fails++; $display("FAIL t5_word0: got %h expected %h", cap[base % 64], {32'd4, 32'd4}); end
        n_checks++; if (cap[(base + 1) % 64] !== EOS_WORD) begin n_fails++; $display("FAIL t5_word1: got %h expected %h", cap[(base + 1) % 64], EOS_WORD); end
    endtask

    task automatic test_restart();
        int base;
        bit ok;
        base = cap_n;
        push(32'd9, 32'd3); push(32'd9, 32'd3); push(32'hFFFF_FFFF, 32'd0);
        tick();
        n_checks++; if (in_read !== 1'b0) begin n_fails++; $display("FAIL t6_no_pop_in_done: got %b expected 0", in_read); end
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL t6_done_held: got %b expected 1", done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL t6_done_cleared: got %b expected 0", done); end
        wait_done(30, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL t6_done: got %b expected 1", ok); end
        n_checks++; if (cap_n - base !== 2) begin n_fails++; $display("FAIL t6_push_count: got %0d expected 2", cap_n - base); end
        n_checks++; if (cap[base % 64] !== {32'd9, 32'd3}) begin n_fails++; $display("FAIL t6_word0: got %h expected %h", cap[base % 64], {32'd9, 32'd3}); end
        n_checks++; if (in_cnt !== 32'd2) begin n_fails++; $display("FAIL t6_in_cnt: got %0d expected 2", in_cnt); end
        n_checks++; if (out_cnt !== 32'd1) begin n_fails++; $display("FAIL t6_out_cnt: got %0d expected 1", out_cnt); end
    endtask

    initial begin
        test_reset();
        test_merge_basic();
        test_eos_only();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
